// File: rtl/udp_ram_stream_reader.sv
// Read-side streamer for the UDP/OSD packet RAM: fetches len bytes from base_addr
// through the RAM's registered read path and emits them as a valid/ready byte stream.
module udp_ram_stream_reader #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 2;
    localparam logic [ADDR_WIDTH:0] ONE_L   = 1;
    localparam logic [PW-1:0]       ONE_P   = 1;
    localparam logic [CW-1:0]       ONE_C   = 1;
    localparam logic [CW-1:0]       DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [ADDR_WIDTH:0]   len_r;
    logic [ADDR_WIDTH:0]   issued;
    logic [ADDR_WIDTH:0]   popped;
    logic                  vld_p0, vld_p1, vld_p2;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         credit_used;
    logic                  issue, push, pop;

    assign m_valid = (fifo_count != '0);
    assign m_data  = m_valid ? fifo_mem[rd_ptr] : '0;
    assign m_last  = m_valid && (popped == len_r - ONE_L);
    assign pop     = m_valid && m_ready;
    assign push    = vld_p2;

    // A credit is held from issue until the byte leaves the FIFO; a pop this cycle
    // releases its credit early so a continuous stream has no bubbles.
    assign credit_used = fifo_count
                       + {{(CW-1){1'b0}}, vld_p0}
                       + {{(CW-1){1'b0}}, vld_p1}
                       + {{(CW-1){1'b0}}, vld_p2}
                       - {{(CW-1){1'b0}}, pop};
    assign issue = (state == RUN) && (issued < len_r) && (credit_used < DEPTH_C);

    always_ff @(posedge rd_clk) begin
        if (push) fifo_mem[wr_ptr] <= ram_rd_data;
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_rd_addr <= '0;
            issued      <= '0;
            popped      <= '0;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            // p0: address register, p1: RAM address register, p2: RAM output register
            vld_p0 <= issue;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;

            if (issue) begin
                ram_rd_addr <= base_r + issued[ADDR_WIDTH-1:0];
                issued      <= issued + ONE_L;
            end
            if (push) wr_ptr <= wr_ptr + ONE_P;
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_P;
                popped <= popped + ONE_L;
            end
            fifo_count <= fifo_count + (push ? ONE_C : '0) - (pop ? ONE_C : '0);

            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        issued <= '0;
                        popped <= '0;
                        busy   <= 1'b1;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (pop && m_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Command operands are datapath registers and need no reset.
    always_ff @(posedge rd_clk) begin
        if (state == IDLE && start) begin
            base_r <= base_addr;
            len_r  <= len;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst_n && push && !pop)
            assert (fifo_count < DEPTH_C) else $error("udp_ram_stream_reader: fifo overflow");
    end

endmodule

// File: tb/tb_udp_ram_stream_reader.sv
// Bench for udp_ram_stream_reader: RAM model with two-register read path and a
// queue-based reference of the expected byte stream.
module tb_udp_ram_stream_reader;

    localparam int AW = 11;
    localparam int DW = 8;
    localparam int NWORDS = 2 ** AW;

    logic          rd_clk = 1'b0;
    logic          rd_rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy, done;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic [DW-1:0] m_data;
    logic          m_valid, m_last, m_ready;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem [NWORDS];
    logic [AW-1:0] ram_addr_q;

    always #5 rd_clk = ~rd_clk;

    always @(posedge rd_clk) begin
        ram_addr_q  <= ram_rd_addr;
        ram_rd_data <= mem[ram_addr_q];
    end

    udp_ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .rd_clk      (rd_clk),
        .rd_rst_n    (rd_rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    32'(busy),        32'd0);
        check({tag, "_done"},    32'(done),        32'd0);
        check({tag, "_m_valid"}, 32'(m_valid),     32'd0);
        check({tag, "_m_last"},  32'(m_last),      32'd0);
        check({tag, "_rd_addr"}, 32'(ram_rd_addr), 32'd0);
        check({tag, "_m_data"},  32'(m_data),      32'd0);
    endtask

    // Runs one transfer. k counts negedges after the start edge S (k=0 is just after S).
    task automatic run_xfer(input logic [AW-1:0] b, input int n, input int ready_pct,
                            input bit timing, input int inject_k, input int rst_after);
        logic [DW-1:0] expq[$];
        logic [DW-1:0] held;
        int            beats;
        int            done_k;
        bit            stall;
        for (int i = 0; i < n; i++) expq.push_back(mem[(int'(b) + i) % NWORDS]);

        @(negedge rd_clk);
        start     = 1'b1;
        base_addr = b;
        len       = (AW+1)'(n);
        @(negedge rd_clk);
        start     = 1'b0;
        base_addr = AW'($urandom);
        len       = (AW+1)'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);

        beats  = 0;
        done_k = -1;
        stall  = 1'b0;
        held   = '0;
        for (int k = 0; k < 4 * n + 40; k++) begin
            if (k == inject_k) begin
                start     = 1'b1;
                base_addr = 11'h123;
                len       = 12'd3;
            end else begin
                start = 1'b0;
            end
            if (rst_after >= 0 && beats == rst_after) begin
                rd_rst_n = 1'b0;
                @(negedge rd_clk);
                rd_rst_n = 1'b1;
                check_reset_outputs("midreset");
                for (int j = 0; j < 6; j++) begin
                    @(negedge rd_clk);
                    check("post_reset_done",  32'(done),    32'd0);
                    check("post_reset_valid", 32'(m_valid), 32'd0);
                end
                return;
            end
            if (done) begin
                done_k = k;
                break;
            end
            m_ready = ($urandom_range(99) < ready_pct);
            if (stall) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data",  32'(m_data),  32'(held));
            end
            if (timing && n <= 8 && k >= 1 && k <= n)
                check("rd_addr", 32'(ram_rd_addr), (int'(b) + k - 1) % NWORDS);
            if (m_valid && m_ready) begin
                if (beats >= n) begin
                    check("extra_beat", beats, n - 1);
                end else begin
                    check("data", 32'(m_data), 32'(expq[beats]));
                    check("last", 32'(m_last), 32'(beats == n - 1));
                    if (timing && beats == 0) check("first_valid_latency", k, 4);
                end
                beats++;
            end
            stall = m_valid && !m_ready;
            held  = m_data;
            @(negedge rd_clk);
        end
        start = 1'b0;
        check("beat_count", beats, n);
        if (timing) check("done_latency", done_k, (n == 0) ? 0 : 4 + n);
        else        check("done_seen", 32'(done_k >= 0), 32'd1);
        @(negedge rd_clk);
        check("busy_clear", 32'(busy), 32'd0);
        check("done_single", 32'(done), 32'd0);
        @(negedge rd_clk);
        check("stay_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rd_rst_n  = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        m_ready   = 1'b0;
        for (int i = 0; i < NWORDS; i++) mem[i] = 8'(i);

        repeat (3) @(negedge rd_clk);
        check_reset_outputs("reset");
        rd_rst_n = 1'b1;
        @(negedge rd_clk);

        // basic stream and address wrap
        run_xfer(11'h010, 5, 100, 1'b1, -1, -1);
        run_xfer(11'h7FE, 4, 100, 1'b1, -1, -1);

        // random contents under random backpressure
        for (int i = 0; i < NWORDS; i++) mem[i] = 8'($urandom);
        run_xfer(AW'($urandom), 64, 50, 1'b0, -1, -1);
        run_xfer(AW'($urandom), 37, 25, 1'b0, -1, -1);

        // zero length, then a start ignored while busy
        run_xfer(11'h200, 0, 100, 1'b1, -1, -1);
        run_xfer(11'h055, 8, 100, 1'b1, 2, -1);

        // reset after 10 beats, then a fresh transfer
        run_xfer(AW'($urandom), 100, 100, 1'b0, -1, 10);
        run_xfer(11'h3A0, 20, 100, 1'b1, -1, -1);

        // full-size transfer wrapping the whole RAM
        run_xfer(AW'($urandom), 2048, 100, 1'b1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
